proj_fm_pingpong_ram: RTL and testbench
=======================================

PROJ_FM_PINGPONG_RAM -- requirements
Module: proj_fm_pingpong_ram

Interface
REQ-001 SHALL have parameter BUFFERS, default 2: number of feature-map buffers in rotation, minimum 2.
REQ-002 SHALL have parameter RAMS, default 2: RAMs per buffer.
REQ-003 SHALL have parameter ENTRIES, default 4: entries per RAM.
REQ-004 SHALL have parameter OFFSET, default 8: offset cells per entry.
REQ-005 SHALL have parameter DATA_BITS, default 8: cell width.
REQ-006 SHALL derive BUF_SIZE = RAMS*ENTRIES*OFFSET and ADDR_BITS = $clog2(BUF_SIZE), with a minimum of 1.
REQ-007 SHALL have in_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have in_rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have in_wvalid, input, 1 bit: write beat offered.
REQ-010 SHALL have out_wready, output, 1 bit: write beat accepted when high with in_wvalid.
REQ-011 SHALL have in_wdata, input, DATA_BITS: write cell.
REQ-012 SHALL have out_rvalid, output, 1 bit: out_rdata holds a valid cell.
REQ-013 SHALL have in_rready, input, 1 bit: consumer takes the cell when high with out_rvalid.
REQ-014 SHALL have out_rdata, output, DATA_BITS: read cell (registered).
REQ-015 SHALL have out_full_cnt, output, $clog2(BUFFERS+1): number of buffers that are full and not yet released.

Function
REQ-016 SHALL fill the write buffer (wbuf) at sequential addresses 0..BUF_SIZE-1, one cell per accepted beat.
REQ-017 SHALL mark wbuf full on the beat at address BUF_SIZE-1, then advance wbuf to (wbuf+1) mod BUFFERS and reset the write address to 0.
REQ-018 SHALL drive out_wready = (out_full_cnt != BUFFERS); when all buffers are full, writes stall with no data loss.
REQ-019 SHALL issue a read of rbuf at the current read address when out_full_cnt != 0 and (!out_rvalid || in_rready).
REQ-020 SHALL present read data on out_rdata with out_rvalid high one cycle after issue, and hold it stable while out_rvalid && !in_rready.
REQ-021 SHALL sustain a throughput of one cell per cycle on each side with continuous valid and ready.
REQ-022 SHALL release rbuf on the issue of address BUF_SIZE-1 (decrement the count, advance rbuf mod BUFFERS, reset the read address to 0).
REQ-023 SHALL leave out_full_cnt unchanged when a fill completion and a release occur in the same cycle.
REQ-024 SHALL keep write and read to different buffers in the same cycle independent; same-buffer access is impossible by construction.
REQ-025 SHALL stream buffers in fill order (FIFO of buffers); address and buffer pointers wrap without a gap cycle.

Reset
REQ-026 SHALL on in_rst clear the write and read addresses, wbuf, rbuf and out_full_cnt to 0, out_rvalid to 0 and out_rdata to 0; out_wready becomes 1 the cycle after reset.
REQ-027 SHALL discard partially filled or partially read buffers on reset mid-operation; RAM contents are not cleared.
REQ-028 SHALL ignore in_wvalid and in_rready while in_rst is high.

Configuration
REQ-029 SHALL, with PROJ_FM_REPLAY_EN defined, add input in_replay (1 bit); if in_replay is high when address BUF_SIZE-1 of rbuf is issued, the buffer is not released and reading restarts at address 0 of the same rbuf.
REQ-030 SHALL, without PROJ_FM_REPLAY_EN, omit in_replay and always release per REQ-022.

Structure
REQ-031 SHALL place the default parameter constants, a buf_size function and a pointer typedef in package proj_fm_pkg.
REQ-032 SHALL instantiate BUFFERS copies of sub-module proj_fm_bank: one write port, one synchronous read port, BUF_SIZE x DATA_BITS, no reset.

Verification (defaults, BUF_SIZE=64)
REQ-033 SHALL test: write 64 beats 0..63 with in_rready=1 -> out_full_cnt=1 after beat 63, then 64 reads return 0..63 in order with out_rvalid=1 on consecutive cycles.
REQ-034 SHALL test: write 128 beats with in_rready=0 -> out_wready=0 after beat 127, out_full_cnt=2; a 129th beat is held until a buffer is released.
REQ-035 SHALL test: random in_rready backpressure over 4 buffers of data -> output sequence equals input sequence, with no duplicates or drops.
REQ-036 SHALL test: a fill completion and a release in the same cycle with out_full_cnt=1 -> out_full_cnt stays 1.
REQ-037 SHALL test: in_rst asserted after 30 writes -> out_full_cnt=0, out_rvalid=0, out_rdata=0; the next 64 writes fill buffer 0 from address 0.
REQ-038 SHALL test, with PROJ_FM_REPLAY_EN: in_replay=1 on the first pass -> buffer 0 is streamed twice (0..63, 0..63) and out_full_cnt is unchanged until the second pass ends.

Source files
------------

// File: rtl/proj_fm_pkg.sv
// Shared constants, sizing helpers and pointer type for the feature-map ping-pong RAM.
package proj_fm_pkg;

    localparam int unsigned DEF_BUFFERS   = 2;
    localparam int unsigned DEF_RAMS      = 2;
    localparam int unsigned DEF_ENTRIES   = 4;
    localparam int unsigned DEF_OFFSET    = 8;
    localparam int unsigned DEF_DATA_BITS = 8;

    // Cells held by one feature-map buffer
    function automatic int unsigned buf_size(input int unsigned rams,
                                             input int unsigned entries,
                                             input int unsigned offset);
        return rams * entries * offset;
    endfunction

    // Address width for n locations, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_PTR_BITS = clog2_min1(DEF_BUFFERS);

    // Buffer index at the default rotation depth
    typedef logic [DEF_PTR_BITS-1:0] buf_ptr_t;

endpackage

// File: rtl/proj_fm_bank.sv
// One feature-map buffer: single write port, registered read port, no reset on storage.
module proj_fm_bank
    import proj_fm_pkg::*;
#(
    parameter int unsigned DEPTH     = buf_size(DEF_RAMS, DEF_ENTRIES, DEF_OFFSET),
    parameter int unsigned ADDR_BITS = clog2_min1(DEPTH),
    parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 in_clk,
    input  logic                 in_wen,
    input  logic [ADDR_BITS-1:0] in_waddr,
    input  logic [DATA_BITS-1:0] in_wdata,
    input  logic                 in_ren,
    input  logic [ADDR_BITS-1:0] in_raddr,
    output logic [DATA_BITS-1:0] out_rdata
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Write on enable; read data only updates on a read enable so it holds under backpressure
    always_ff @(posedge in_clk) begin
        if (in_wen) begin
            mem[in_waddr] <= in_wdata;
        end
        if (in_ren) begin
            out_rdata <= mem[in_raddr];
        end
    end

endmodule

// File: rtl/proj_fm_pingpong_ram.sv
// Rotating set of feature-map buffers streamed in fill order.
// Optional feature: define PROJ_FM_REPLAY_EN to add in_replay (re-stream a buffer instead of releasing it).
module proj_fm_pingpong_ram
    import proj_fm_pkg::*;
#(
    parameter int unsigned BUFFERS   = DEF_BUFFERS,
    parameter int unsigned RAMS      = DEF_RAMS,
    parameter int unsigned ENTRIES   = DEF_ENTRIES,
    parameter int unsigned OFFSET    = DEF_OFFSET,
    parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
    input  logic                             in_clk,
    input  logic                             in_rst,
    input  logic                             in_wvalid,
    output logic                             out_wready,
    input  logic [DATA_BITS-1:0]             in_wdata,
    output logic                             out_rvalid,
    input  logic                             in_rready,
`ifdef PROJ_FM_REPLAY_EN
    input  logic                             in_replay,
`endif
    output logic [DATA_BITS-1:0]             out_rdata,
    output logic [$clog2(BUFFERS+1)-1:0]     out_full_cnt
);

    localparam int unsigned BUF_SIZE  = buf_size(RAMS, ENTRIES, OFFSET);
    localparam int unsigned ADDR_BITS = clog2_min1(BUF_SIZE);
    localparam int unsigned PTR_BITS  = clog2_min1(BUFFERS);
    localparam int unsigned CNT_BITS  = $clog2(BUFFERS + 1);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(BUF_SIZE - 1);
    localparam logic [PTR_BITS-1:0]  LAST_BUF  = PTR_BITS'(BUFFERS - 1);
    localparam logic [CNT_BITS-1:0]  ALL_FULL  = CNT_BITS'(BUFFERS);

    logic [ADDR_BITS-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [PTR_BITS-1:0]  wbuf_q, wbuf_d, rbuf_q, rbuf_d, rsel_q, rsel_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 rvalid_q, rvalid_d, wready_q, wready_d;
    logic                 wr_acc_c, rd_iss_c, fill_c, release_c, replay_c;

    logic [DATA_BITS-1:0] bank_rdata [BUFFERS];

`ifdef PROJ_FM_REPLAY_EN
    assign replay_c = in_replay;
`else
    assign replay_c = 1'b0;
`endif

    // Handshake qualifiers; both sides are ignored while reset is asserted
    assign wr_acc_c  = in_wvalid && wready_q && !in_rst;
    assign rd_iss_c  = (cnt_q != '0) && (!rvalid_q || in_rready) && !in_rst;
    assign fill_c    = wr_acc_c && (waddr_q == LAST_ADDR);
    assign release_c = rd_iss_c && (raddr_q == LAST_ADDR) && !replay_c;

    // Next-state for pointers, occupancy and read-valid
    always_comb begin
        waddr_d  = waddr_q;
        raddr_d  = raddr_q;
        wbuf_d   = wbuf_q;
        rbuf_d   = rbuf_q;
        rsel_d   = rsel_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;

        if (wr_acc_c) begin
            waddr_d = fill_c ? '0 : waddr_q + ADDR_BITS'(1);
            if (fill_c) begin
                wbuf_d = (wbuf_q == LAST_BUF) ? '0 : wbuf_q + PTR_BITS'(1);
            end
        end

        if (rd_iss_c) begin
            raddr_d  = (raddr_q == LAST_ADDR) ? '0 : raddr_q + ADDR_BITS'(1);
            rsel_d   = rbuf_q;
            rvalid_d = 1'b1;
            if (release_c) begin
                rbuf_d = (rbuf_q == LAST_BUF) ? '0 : rbuf_q + PTR_BITS'(1);
            end
        end else if (in_rready) begin
            rvalid_d = 1'b0;
        end

        case ({fill_c, release_c})
            2'b10:   cnt_d = cnt_q + CNT_BITS'(1);
            2'b01:   cnt_d = cnt_q - CNT_BITS'(1);
            default: cnt_d = cnt_q;
        endcase

        wready_d = (cnt_d != ALL_FULL);
    end

    // State registers with synchronous reset; partial buffers are simply dropped
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            waddr_q  <= '0;
            raddr_q  <= '0;
            wbuf_q   <= '0;
            rbuf_q   <= '0;
            rsel_q   <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            wready_q <= 1'b1;
        end else begin
            waddr_q  <= waddr_d;
            raddr_q  <= raddr_d;
            wbuf_q   <= wbuf_d;
            rbuf_q   <= rbuf_d;
            rsel_q   <= rsel_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            wready_q <= wready_d;
        end
    end

    // Buffer storage; the writer and reader never target the same bank in one cycle
    for (genvar b = 0; b < BUFFERS; b++) begin : g_bank
        proj_fm_bank #(
            .DEPTH     (BUF_SIZE),
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS)
        ) u_bank (
            .in_clk    (in_clk),
            .in_wen    (wr_acc_c && (wbuf_q == PTR_BITS'(b))),
            .in_waddr  (waddr_q),
            .in_wdata  (in_wdata),
            .in_ren    (rd_iss_c && (rbuf_q == PTR_BITS'(b))),
            .in_raddr  (raddr_q),
            .out_rdata (bank_rdata[b])
        );
    end

    // Output data comes from the bank read register of the last issued buffer, zero when idle
    assign out_rdata    = rvalid_q ? bank_rdata[rsel_q] : '0;
    assign out_rvalid   = rvalid_q;
    assign out_wready   = wready_q;
    assign out_full_cnt = cnt_q;

endmodule

// File: tb/tb_proj_fm_pingpong_ram.sv
// Directed bench for proj_fm_pingpong_ram at default parameters (BUF_SIZE = 64).
// Define PROJ_FM_REPLAY_EN for both bench and RTL to exercise the replay option.
module tb_proj_fm_pingpong_ram;

    logic       in_clk;
    logic       in_rst;
    logic       in_wvalid;
    logic       out_wready;
    logic [7:0] in_wdata;
    logic       out_rvalid;
    logic       in_rready;
    logic [7:0] out_rdata;
    logic [1:0] out_full_cnt;
`ifdef PROJ_FM_REPLAY_EN
    logic       in_replay;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int n_rd     = 0;
    logic [7:0] exp_q [$];

    proj_fm_pingpong_ram dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_wvalid    (in_wvalid),
        .out_wready   (out_wready),
        .in_wdata     (in_wdata),
        .out_rvalid   (out_rvalid),
        .in_rready    (in_rready),
`ifdef PROJ_FM_REPLAY_EN
        .in_replay    (in_replay),
`endif
        .out_rdata    (out_rdata),
        .out_full_cnt (out_full_cnt)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        logic       rst;
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       ex_wready;
        logic       ex_rvalid;
        logic [7:0] ex_rdata;
        logic [1:0] ex_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: score the handshakes that complete at this edge, then sample 1 time unit later
    task automatic tick();
        bit wacc;
        bit racc;
        logic [7:0] e;
        wacc = in_wvalid && out_wready && !in_rst;
        racc = out_rvalid && in_rready && !in_rst;
        if (racc) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("rdata_sb", 32'(out_rdata), 32'(e));
            end
            n_rd++;
        end
        if (wacc) begin
            exp_q.push_back(in_wdata);
            n_wr++;
        end
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_reset();
        in_rst    = 1'b1;
        in_wvalid = 1'b0;
        in_rready = 1'b0;
        tick();
        in_rst = 1'b0;
        exp_q.delete();
        n_wr = 0;
        n_rd = 0;
    endtask

    // Offer one beat that must be accepted immediately
    task automatic write_beat(input logic [7:0] d);
        in_wvalid = 1'b1;
        in_wdata  = d;
        check("wready_on_beat", 32'(out_wready), 32'd1);
        tick();
        in_wvalid = 1'b0;
    endtask

    vec_t vecs [6];

    initial begin
        int guard;
        int cycles;
        in_rst    = 1'b1;
        in_wvalid = 1'b0;
        in_wdata  = 8'h00;
        in_rready = 1'b0;
`ifdef PROJ_FM_REPLAY_EN
        in_replay = 1'b0;
`endif

        // Reset behaviour and first writes; beats offered during reset must be ignored
        vecs[0] = '{1'b1, 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 8'hEF, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        vecs[2] = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        vecs[4] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0};
        vecs[5] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        for (int i = 0; i < 6; i++) begin
            in_rst    = vecs[i].rst;
            in_wvalid = vecs[i].wv;
            in_wdata  = vecs[i].wd;
            in_rready = vecs[i].rr;
            tick();
            check("vec_wready", 32'(out_wready),   32'(vecs[i].ex_wready));
            check("vec_rvalid", 32'(out_rvalid),   32'(vecs[i].ex_rvalid));
            check("vec_rdata",  32'(out_rdata),    32'(vecs[i].ex_rdata));
            check("vec_cnt",    32'(out_full_cnt), 32'(vecs[i].ex_cnt));
        end
        in_rst = 1'b0;

        // Complete buffer 0 (beats 2..63 after the two above), then stream it back
        in_rready = 1'b1;
        for (int i = 2; i < 64; i++) begin
            if (i == 63) check("cnt_before_last_beat", 32'(out_full_cnt), 32'd0);
            write_beat(8'(i));
        end
        check("cnt_after_fill", 32'(out_full_cnt), 32'd1);
        check("rvalid_at_fill", 32'(out_rvalid), 32'd0);
        for (int k = 0; k < 64; k++) begin
            tick();
            check("stream_rvalid", 32'(out_rvalid), 32'd1);
            check("stream_rdata",  32'(out_rdata),  32'(k));
        end
        check("cnt_after_release", 32'(out_full_cnt), 32'd0);
        tick();
        check("rvalid_idle", 32'(out_rvalid), 32'd0);
        check("sb_empty_a", 32'(exp_q.size()), 32'd0);

        // Fill both buffers with no consumer; the 129th beat must wait for a release
        do_reset();
        for (int i = 0; i < 128; i++) write_beat(8'(100 + i));
        check("cnt_all_full", 32'(out_full_cnt), 32'd2);
        check("wready_all_full", 32'(out_wready), 32'd0);
        check("rvalid_stalled", 32'(out_rvalid), 32'd1);
        check("rdata_stalled", 32'(out_rdata), 32'd100);
        in_wvalid = 1'b1;
        in_wdata  = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_wready", 32'(out_wready), 32'd0);
            check("hold_cnt", 32'(out_full_cnt), 32'd2);
            check("hold_rdata", 32'(out_rdata), 32'd100);
        end
        in_rready = 1'b1;
        guard = 0;
        while (in_wvalid && guard < 200) begin
            if (out_wready) begin
                tick();
                in_wvalid = 1'b0;
                check("reads_before_129th", 32'(n_rd), 32'd64);
            end else begin
                tick();
            end
            guard++;
        end
        check("beat129_timeout", 32'(in_wvalid), 32'd0);
        guard = 0;
        while (n_rd < 128 && guard < 200) begin
            tick();
            guard++;
        end
        check("drain_b_count", 32'(n_rd), 32'd128);
        tick();
        check("partial_left", 32'(exp_q.size()), 32'd1);
        check("cnt_partial", 32'(out_full_cnt), 32'd0);
        check("rvalid_partial", 32'(out_rvalid), 32'd0);

        // Fill completion and release in the same cycle, full throughput on both sides
        do_reset();
        in_rready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            write_beat(8'(3 * i));
            if (i >= 64) check("overlap_cnt", 32'(out_full_cnt), 32'd1);
            if (i >= 64) check("overlap_rvalid", 32'(out_rvalid), 32'd1);
        end
        check("same_cycle_cnt", 32'(out_full_cnt), 32'd1);
        cycles = 0;
        while (n_rd < 128 && cycles < 300) begin
            check("drain_rvalid", 32'(out_rvalid), 32'd1);
            tick();
            cycles++;
        end
        check("drain_cycles", 32'(cycles), 32'd65);
        check("cnt_after_overlap", 32'(out_full_cnt), 32'd0);

        // Random data and backpressure over four buffers of data
        do_reset();
        guard = 0;
        while (n_rd < 256 && guard < 5000) begin
            in_wvalid = (n_wr < 256) ? ($urandom_range(0, 3) != 0) : 1'b0;
            in_wdata  = 8'($urandom);
            in_rready = ($urandom_range(0, 2) != 0);
            tick();
            guard++;
        end
        in_wvalid = 1'b0;
        check("rand_reads", 32'(n_rd), 32'd256);
        check("rand_writes", 32'(n_wr), 32'd256);
        in_rready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rand_no_extra", 32'(out_rvalid), 32'd0);
        check("sb_empty_rand", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation with a stalled output and a partly filled second buffer
        do_reset();
        for (int i = 0; i < 94; i++) write_beat(8'(i));
        check("pre_rst_rvalid", 32'(out_rvalid), 32'd1);
        in_rst    = 1'b1;
        in_wvalid = 1'b1;
        in_rready = 1'b1;
        tick();
        in_rst    = 1'b0;
        in_wvalid = 1'b0;
        in_rready = 1'b0;
        exp_q.delete();
        n_rd = 0;
        check("rst_cnt", 32'(out_full_cnt), 32'd0);
        check("rst_rvalid", 32'(out_rvalid), 32'd0);
        check("rst_rdata", 32'(out_rdata), 32'd0);
        check("rst_wready", 32'(out_wready), 32'd1);
        for (int i = 0; i < 63; i++) write_beat(8'(200 + i));
        check("rst_refill_cnt63", 32'(out_full_cnt), 32'd0);
        write_beat(8'(263));
        check("rst_refill_cnt64", 32'(out_full_cnt), 32'd1);
        in_rready = 1'b1;
        guard = 0;
        while (n_rd < 64 && guard < 200) begin
            tick();
            guard++;
        end
        check("rst_refill_reads", 32'(n_rd), 32'd64);

`ifdef PROJ_FM_REPLAY_EN
        // Replay: buffer 0 streamed twice, occupancy unchanged until the second pass ends
        do_reset();
        in_replay = 1'b1;
        for (int i = 0; i < 64; i++) write_beat(8'(i));
        in_rready = 1'b1;
        for (int k = 0; k < 128; k++) begin
            @(posedge in_clk);
            #1;
            check("replay_rvalid", 32'(out_rvalid), 32'd1);
            check("replay_rdata", 32'(out_rdata), 32'(k % 64));
            if (k < 127) check("replay_cnt", 32'(out_full_cnt), 32'd1);
            if (k == 63) in_replay = 1'b0;
        end
        check("replay_cnt_end", 32'(out_full_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
